// File: rtl/burst_sequencer.sv
// Timed burst sequencer: queues burst commands and, at each command's start
// time, drives the radiate/receive interval train and the DDS start/enable.
//
// Ports:
//   CLK, rst_n         clock, async active-low reset
//   TIME, TIME_UPDATE  system time and its re-set pulse (flushes everything)
//   ABORT              stop the running burst, keep the queue
//   CMD_*              command write port (CMD_WR strobes the fields in)
//   CMD_COUNT/FULL/ERR queue fill level, full flag, rejected-write pulse
//   LATE, DONE, BUSY   dropped-command pulse, burst-complete pulse, not idle
//   En_Iz, En_Pr       radiate / receive enables
//   DDS_start, DDS_EN  DDS program pulse and output enable
//   PULSE_IDX          index of the pulse being generated
module burst_sequencer #(
  parameter int TW    = 64,
  parameter int IW    = 32,
  parameter int NW    = 16,
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   rst_n,
  input  logic [TW-1:0]          TIME,
  input  logic                   TIME_UPDATE,
  input  logic                   ABORT,
  input  logic                   CMD_WR,
  input  logic [TW-1:0]          CMD_TIME_START,
  input  logic [NW-1:0]          CMD_N_impuls,
  input  logic [1:0]             CMD_TYPE,
  input  logic [IW-1:0]          CMD_Ti,
  input  logic [IW-1:0]          CMD_Tblank1,
  input  logic [IW-1:0]          CMD_Tp,
  input  logic [IW-1:0]          CMD_Tblank2,
  output logic [$clog2(DEPTH):0] CMD_COUNT,
  output logic                   CMD_FULL,
  output logic                   CMD_ERR,
  output logic                   LATE,
  output logic                   BUSY,
  output logic                   En_Iz,
  output logic                   En_Pr,
  output logic                   DDS_start,
  output logic                   DDS_EN,
  output logic [NW-1:0]          PULSE_IDX,
  output logic                   DONE
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [IW-1:0] IONE = 1;
  localparam logic [NW-1:0] NONE = 1;

  typedef struct packed {
    logic [TW-1:0] st;
    logic [NW-1:0] n;
    logic [1:0]    typ;
    logic [IW-1:0] ti;
    logic [IW-1:0] tb1;
    logic [IW-1:0] tp;
    logic [IW-1:0] tb2;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_IZ, S_BL1, S_PR, S_BL2
  } state_t;

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  state_t        state_q, state_d;
  logic [IW-1:0] tmr_q, tmr_d;
  logic [NW-1:0] idx_q, idx_d;
  cmd_t          cur_q, cur_d;

  logic full, bad, push, pop, kill;
  logic fire, first, last, burst_d;
  logic late_d, done_d, err_d, start_d, en_d;

  assign full = cnt_q == CW'(DEPTH);
  assign bad  = CMD_TYPE == 2'd3 || CMD_Ti == '0 ||
                CMD_Tp == '0 ||
                (CMD_TYPE != 2'd2 && CMD_N_impuls == '0);
  assign push = CMD_WR && !TIME_UPDATE && !full && !bad;
  assign err_d = CMD_WR && !TIME_UPDATE && (full || bad);
  assign pop  = state_q == S_IDLE && cnt_q != '0 &&
                !TIME_UPDATE;
  assign kill = TIME_UPDATE ||
                (ABORT && state_q != S_IDLE &&
                 state_q != S_WAIT);

  always_comb begin
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    wp_d  = push ? wp_q + 1'b1 : wp_q;
    rp_d  = pop ? rp_q + 1'b1 : rp_q;
    if (TIME_UPDATE) begin
      cnt_d = '0;
      wp_d  = '0;
      rp_d  = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    idx_d   = idx_q;
    cur_d   = cur_q;
    late_d  = 1'b0;
    done_d  = 1'b0;
    fire    = 1'b0;
    first   = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      S_IDLE: if (pop) begin
        cur_d   = mem_q[rp_q];
        idx_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: if (TIME == cur_q.st) begin
        state_d = S_IZ;
        tmr_d   = cur_q.ti - IONE;
        fire    = 1'b1;
        first   = 1'b1;
      end else if (TIME > cur_q.st) begin
        late_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_IZ: if (tmr_q != '0) begin
        tmr_d = tmr_q - IONE;
      end else if (cur_q.tb1 != '0) begin
        state_d = S_BL1;
        tmr_d   = cur_q.tb1 - IONE;
      end else begin
        state_d = S_PR;
        tmr_d   = cur_q.tp - IONE;
      end
      S_BL1: if (tmr_q != '0) begin
        tmr_d = tmr_q - IONE;
      end else begin
        state_d = S_PR;
        tmr_d   = cur_q.tp - IONE;
      end
      S_PR: if (tmr_q != '0) begin
        tmr_d = tmr_q - IONE;
      end else if (cur_q.tb2 != '0) begin
        state_d = S_BL2;
        tmr_d   = cur_q.tb2 - IONE;
      end else begin
        last = 1'b1;
      end
      S_BL2: if (tmr_q != '0) begin
        tmr_d = tmr_q - IONE;
      end else begin
        last = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // continuous bursts ignore N and let the index wrap
    if (last) begin
      if (cur_q.typ == 2'd2 || idx_q < cur_q.n - NONE) begin
        idx_d   = idx_q + NONE;
        state_d = S_IZ;
        tmr_d   = cur_q.ti - IONE;
        fire    = 1'b1;
      end else begin
        done_d  = 1'b1;
        idx_d   = '0;
        state_d = S_IDLE;
      end
    end
    if (kill) begin
      state_d = S_IDLE;
      idx_d   = '0;
      late_d  = 1'b0;
      done_d  = 1'b0;
      fire    = 1'b0;
    end
  end

  assign burst_d = state_d != S_IDLE && state_d != S_WAIT;
  assign en_d    = cur_d.typ == 2'd0 ? state_d == S_IZ
                                     : burst_d;
  // coherent/continuous program the DDS once per burst
  assign start_d = fire && (cur_q.typ == 2'd0 || first);

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wp_q] <= '{st: CMD_TIME_START, n: CMD_N_impuls,
                       typ: CMD_TYPE, ti: CMD_Ti,
                       tb1: CMD_Tblank1, tp: CMD_Tp,
                       tb2: CMD_Tblank2};
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      idx_q     <= '0;
      cur_q     <= '0;
      CMD_FULL  <= 1'b0;
      CMD_ERR   <= 1'b0;
      LATE      <= 1'b0;
      BUSY      <= 1'b0;
      En_Iz     <= 1'b0;
      En_Pr     <= 1'b0;
      DDS_start <= 1'b0;
      DDS_EN    <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      idx_q     <= idx_d;
      cur_q     <= cur_d;
      CMD_FULL  <= cnt_d == CW'(DEPTH);
      CMD_ERR   <= err_d;
      LATE      <= late_d;
      BUSY      <= state_d != S_IDLE;
      En_Iz     <= state_d == S_IZ;
      En_Pr     <= state_d == S_PR;
      DDS_start <= start_d;
      DDS_EN    <= en_d;
      DONE      <= done_d;
    end
  end

  assign CMD_COUNT = cnt_q;
  assign PULSE_IDX = idx_q;

endmodule

// File: tb/tb_burst_sequencer.sv
// Testbench for burst_sequencer: random and directed bursts checked
// against a time-based model of the pulse train.
module tb_burst_sequencer;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic [63:0] tm;
  logic        TIME_UPDATE, ABORT, CMD_WR;
  logic [63:0] c_st;
  logic [15:0] c_n;
  logic [1:0]  c_typ;
  logic [31:0] c_ti, c_tb1, c_tp, c_tb2;
  logic [2:0]  CMD_COUNT;
  logic        CMD_FULL, CMD_ERR, LATE, BUSY;
  logic        En_Iz, En_Pr, DDS_start, DDS_EN, DONE;
  logic [15:0] PULSE_IDX;

  always #5 CLK = ~CLK;

  burst_sequencer dut (
    .CLK(CLK), .rst_n(rst_n), .TIME(tm),
    .TIME_UPDATE(TIME_UPDATE), .ABORT(ABORT),
    .CMD_WR(CMD_WR), .CMD_TIME_START(c_st),
    .CMD_N_impuls(c_n), .CMD_TYPE(c_typ),
    .CMD_Ti(c_ti), .CMD_Tblank1(c_tb1),
    .CMD_Tp(c_tp), .CMD_Tblank2(c_tb2),
    .CMD_COUNT(CMD_COUNT), .CMD_FULL(CMD_FULL),
    .CMD_ERR(CMD_ERR), .LATE(LATE), .BUSY(BUSY),
    .En_Iz(En_Iz), .En_Pr(En_Pr),
    .DDS_start(DDS_start), .DDS_EN(DDS_EN),
    .PULSE_IDX(PULSE_IDX), .DONE(DONE)
  );

  typedef struct {
    longint unsigned st;
    int unsigned n, typ, ti, tb1, tp, tb2;
  } cmd_t;

  int   checks = 0;
  int   failures = 0;
  int   late_seen = 0;
  cmd_t sched[$];

  function automatic cmd_t mk(longint unsigned st,
    int unsigned n, int unsigned typ, int unsigned ti,
    int unsigned tb1, int unsigned tp, int unsigned tb2);
    cmd_t c;
    c.st = st; c.n = n; c.typ = typ; c.ti = ti;
    c.tb1 = tb1; c.tp = tp; c.tb2 = tb2;
    return c;
  endfunction

  function automatic longint unsigned end_t(cmd_t c);
    return c.st + 1 + longint'(c.n) *
      longint'(c.ti + c.tb1 + c.tp + c.tb2);
  endfunction

  // Expected {En_Iz,En_Pr,DDS_start,DDS_EN,DONE} at time t
  function automatic void model(input longint unsigned t,
    output logic [4:0] v, output bit act,
    output int unsigned k);
    longint unsigned p, off, tot, o, kk, ti, tb1, tp;
    logic iz, pr, ds, en;
    v = '0; act = 0; k = 0;
    foreach (sched[i]) begin
      ti  = sched[i].ti;
      tb1 = sched[i].tb1;
      tp  = sched[i].tp;
      p   = ti + tb1 + tp + sched[i].tb2;
      if (t > sched[i].st) begin
        off = t - sched[i].st - 1;
        tot = sched[i].typ == 2 ? 64'hFFFF_FFFF_FFFF_FFFF
                                : longint'(sched[i].n) * p;
        if (off < tot) begin
          kk = off / p;
          o  = off % p;
          iz = o < ti;
          pr = o >= ti + tb1 && o < ti + tb1 + tp;
          ds = o == 0 && (sched[i].typ == 0 || kk == 0);
          en = sched[i].typ == 0 ? iz : 1'b1;
          v |= {iz, pr, ds, en, 1'b0};
          act = 1;
          k = int'(kk % 65536);
        end else if (off == tot) begin
          v[0] = 1'b1;
        end
      end
    end
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
    tm = tm + 1;
    CMD_WR = 0;
    ABORT = 0;
    TIME_UPDATE = 0;
  endtask

  task automatic put_cmd(input cmd_t c);
    CMD_WR = 1;
    c_st = c.st;
    c_n = 16'(c.n);
    c_typ = 2'(c.typ);
    c_ti = c.ti; c_tb1 = c.tb1;
    c_tp = c.tp; c_tb2 = c.tb2;
  endtask

  task automatic run_check(input longint unsigned t_end);
    logic [4:0]  v, got;
    bit          act;
    int unsigned k;
    for (int g = 0; g < 20000; g++) begin
      model(tm, v, act, k);
      got = {En_Iz, En_Pr, DDS_start, DDS_EN, DONE};
      checks++;
      if (got !== v) begin
        failures++;
        $display("FAIL burst t=%0d got=%b exp=%b", tm, got, v);
      end
      if (act) begin
        checks++;
        if (PULSE_IDX !== 16'(k)) begin
          failures++;
          $display("FAIL pulse_idx t=%0d got=%0d exp=%0d",
                   tm, PULSE_IDX, k);
        end
      end
      if (LATE) late_seen++;
      if (tm >= t_end) break;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 0; tm = 0; TIME_UPDATE = 0; ABORT = 0; CMD_WR = 0;
    c_st = 0; c_n = 0; c_typ = 0;
    c_ti = 0; c_tb1 = 0; c_tp = 0; c_tb2 = 0;
    #12;
    checks++;
    if ({CMD_COUNT, CMD_FULL, CMD_ERR, LATE, BUSY, En_Iz, En_Pr,
         DDS_start, DDS_EN, PULSE_IDX, DONE} !== '0) begin
      failures++;
      $display("FAIL reset_outs got=%b exp=0", {CMD_COUNT, BUSY,
               En_Iz, En_Pr, DDS_start, DDS_EN, DONE});
    end
    @(posedge CLK); #1; rst_n = 1;
    tick(); tick();
    checks++;
    if ({CMD_COUNT, BUSY, En_Iz, DONE} !== '0) begin
      failures++;
      $display("FAIL post_reset got=%b exp=0",
               {CMD_COUNT, BUSY, En_Iz, DONE});
    end
  endtask

  task automatic test_basic(input int unsigned typ);
    cmd_t c;
    TIME_UPDATE = 1;
    tick();
    tm = 10;
    c = mk(100, 2, typ, 3, 1, 2, 0);
    put_cmd(c);
    tick();
    sched = {c};
    run_check(end_t(c) + 1);
    sched.delete();
  endtask

  task automatic test_queue_full();
    cmd_t c;
    put_cmd(mk(tm + 300, 1, 0, 1, 0, 1, 0));
    tick(); tick();
    checks++;
    if (BUSY !== 1'b1 || CMD_COUNT !== 3'd0) begin
      failures++;
      $display("FAIL wait_pending busy=%b cnt=%0d exp 1/0",
               BUSY, CMD_COUNT);
    end
    for (int i = 0; i < 5; i++) begin
      put_cmd(mk(tm + 400 + i, 1, 0, 1, 0, 1, 0));
      tick();
      checks++;
      if (CMD_COUNT !== 3'(i < 4 ? i + 1 : 4)) begin
        failures++;
        $display("FAIL fill_count i=%0d got=%0d exp=%0d",
                 i, CMD_COUNT, i < 4 ? i + 1 : 4);
      end
      checks++;
      if (CMD_ERR !== (i == 4)) begin
        failures++;
        $display("FAIL fill_err i=%0d got=%b exp=%b",
                 i, CMD_ERR, i == 4);
      end
    end
    checks++;
    if (CMD_FULL !== 1'b1) begin
      failures++;
      $display("FAIL full_flag got=%b exp=1", CMD_FULL);
    end
    TIME_UPDATE = 1;
    tick();
    checks++;
    if ({CMD_COUNT, CMD_FULL, BUSY} !== '0) begin
      failures++;
      $display("FAIL flush got=%b exp=0",
               {CMD_COUNT, CMD_FULL, BUSY});
    end
    for (int i = 0; i < 4; i++) begin
      c = mk(tm + 50, i == 0 ? 0 : 1, i == 3 ? 3 : 0,
             i == 1 ? 0 : 2, 0, i == 2 ? 0 : 2, 0);
      put_cmd(c);
      tick();
      checks++;
      if (CMD_ERR !== 1'b1 || CMD_COUNT !== 3'd0) begin
        failures++;
        $display("FAIL invalid i=%0d err=%b cnt=%0d exp 1/0",
                 i, CMD_ERR, CMD_COUNT);
      end
    end
    put_cmd(mk(tm + 50, 0, 2, 2, 0, 2, 0));
    tick();
    checks++;
    if (CMD_ERR !== 1'b0 || CMD_COUNT !== 3'd1) begin
      failures++;
      $display("FAIL cont_n0 err=%b cnt=%0d exp 0/1",
               CMD_ERR, CMD_COUNT);
    end
    TIME_UPDATE = 1;
    tick(); tick();
  endtask

  task automatic test_late();
    cmd_t d;
    put_cmd(mk(tm + 1, 1, 0, 2, 0, 2, 0));
    tick();
    d = mk(tm + 50, 2, 0, 2, 1, 3, 1);
    put_cmd(d);
    tick();
    late_seen = 0;
    sched = {d};
    run_check(end_t(d) + 1);
    sched.delete();
    checks++;
    if (late_seen !== 1) begin
      failures++;
      $display("FAIL late_pulses got=%0d exp=1", late_seen);
    end
  endtask

  task automatic test_cont_abort();
    cmd_t c, d;
    longint unsigned t_a;
    c = mk(tm + 5, 1, 2, 2, 0, 2, 0);
    t_a = c.st + 1 + 3 * 4 + 2;
    put_cmd(c);
    tick();
    d = mk(t_a + 20, 2, 1, $urandom_range(1, 4),
           $urandom_range(0, 2), $urandom_range(1, 4),
           $urandom_range(0, 2));
    put_cmd(d);
    tick();
    sched = {c};
    run_check(t_a);
    ABORT = 1;
    tick();
    checks++;
    if ({En_Iz, En_Pr, DDS_EN, DONE, PULSE_IDX, BUSY} !== '0) begin
      failures++;
      $display("FAIL abort got=%b exp=0",
               {En_Iz, En_Pr, DDS_EN, DONE, PULSE_IDX, BUSY});
    end
    checks++;
    if (CMD_COUNT !== 3'd1) begin
      failures++;
      $display("FAIL abort_keep got=%0d exp=1", CMD_COUNT);
    end
    sched = {d};
    run_check(t_a + 4);
    ABORT = 1;
    run_check(end_t(d) + 1);
    sched.delete();
  endtask

  task automatic test_time_update();
    longint unsigned t0;
    t0 = tm;
    put_cmd(mk(t0 + 4, 1, 1, 30, 0, 5, 0));
    tick();
    for (int i = 0; i < 3; i++) begin
      put_cmd(mk(t0 + 1000 + i, 1, 0, 2, 0, 2, 0));
      tick();
    end
    tick(); tick();
    checks++;
    if (CMD_COUNT !== 3'd3 || En_Iz !== 1'b1) begin
      failures++;
      $display("FAIL tu_setup cnt=%0d iz=%b exp 3/1",
               CMD_COUNT, En_Iz);
    end
    TIME_UPDATE = 1;
    put_cmd(mk(t0 + 2000, 1, 0, 2, 0, 2, 0));
    tick();
    tm = 5000;
    checks++;
    if ({CMD_COUNT, CMD_FULL, CMD_ERR, LATE, BUSY, En_Iz, En_Pr,
         DDS_start, DDS_EN, PULSE_IDX, DONE} !== '0) begin
      failures++;
      $display("FAIL tu_flush cnt=%0d busy=%b iz=%b en=%b exp 0",
               CMD_COUNT, BUSY, En_Iz, DDS_EN);
    end
    tick(); tick(); tick();
    checks++;
    if ({CMD_COUNT, BUSY} !== '0) begin
      failures++;
      $display("FAIL tu_after cnt=%0d busy=%b exp 0/0",
               CMD_COUNT, BUSY);
    end
  endtask

  task automatic test_random();
    cmd_t c;
    for (int it = 0; it < 6; it++) begin
      c = mk(tm + $urandom_range(3, 12), $urandom_range(1, 3),
             $urandom_range(0, 1), $urandom_range(1, 4),
             $urandom_range(0, 3), $urandom_range(1, 4),
             $urandom_range(0, 3));
      put_cmd(c);
      tick();
      sched = {c};
      run_check(end_t(c) + 2);
      sched.delete();
      checks++;
      if ({BUSY, CMD_COUNT} !== '0) begin
        failures++;
        $display("FAIL rand_idle it=%0d busy=%b cnt=%0d exp 0",
                 it, BUSY, CMD_COUNT);
      end
    end
  endtask

  task automatic test_back_to_back();
    cmd_t c, d;
    for (int it = 0; it < 3; it++) begin
      c = mk(tm + $urandom_range(4, 8), $urandom_range(1, 3),
             $urandom_range(0, 1), $urandom_range(1, 3),
             $urandom_range(0, 2), $urandom_range(1, 3),
             $urandom_range(0, 2));
      d = mk(end_t(c) + $urandom_range(2, 5),
             $urandom_range(1, 3), $urandom_range(0, 1),
             $urandom_range(1, 3), $urandom_range(0, 2),
             $urandom_range(1, 3), $urandom_range(0, 2));
      put_cmd(c);
      tick();
      put_cmd(d);
      tick();
      sched = {c, d};
      run_check(end_t(d) + 1);
      sched.delete();
    end
  endtask

  task automatic test_async_reset();
    cmd_t c;
    c = mk(tm + 4, 2, 0, 10, 1, 3, 0);
    put_cmd(c);
    tick();
    put_cmd(mk(tm + 500, 1, 0, 2, 0, 2, 0));
    tick();
    for (int g = 0; g < 50 && tm < c.st + 3; g++) tick();
    checks++;
    if (En_Iz !== 1'b1 || CMD_COUNT !== 3'd1) begin
      failures++;
      $display("FAIL ar_setup iz=%b cnt=%0d exp 1/1",
               En_Iz, CMD_COUNT);
    end
    #2;
    rst_n = 0;
    #1;
    checks++;
    if ({CMD_COUNT, CMD_FULL, CMD_ERR, LATE, BUSY, En_Iz, En_Pr,
         DDS_start, DDS_EN, PULSE_IDX, DONE} !== '0) begin
      failures++;
      $display("FAIL async_reset cnt=%0d busy=%b iz=%b exp 0",
               CMD_COUNT, BUSY, En_Iz);
    end
    tick();
    rst_n = 1;
    tick(); tick();
    checks++;
    if ({CMD_COUNT, BUSY, En_Iz, DDS_EN} !== '0) begin
      failures++;
      $display("FAIL ar_after cnt=%0d busy=%b exp 0/0",
               CMD_COUNT, BUSY);
    end
  endtask

  initial begin
    test_reset();
    test_basic(0);
    test_basic(1);
    test_queue_full();
    test_late();
    test_cont_abort();
    test_time_update();
    test_random();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
